// File: rtl/mdu_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 encodings,
// FSM state codes and the op decoder used by mdu.
package mdu_pkg;

  localparam int ROB_SIZE_WIDTH = 4;

  localparam int MDU_OP_WIDTH = 3;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'b000;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'b001;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'b010;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'b011;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'b100;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'b101;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'b110;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'b111;

  localparam logic [1:0] MDU_S_IDLE = 2'd0;
  localparam logic [1:0] MDU_S_MUL  = 2'd1;
  localparam logic [1:0] MDU_S_DIV  = 2'd2;
  localparam logic [1:0] MDU_S_FIX  = 2'd3;

  typedef struct packed {
    logic is_div;    // divide/remainder family
    logic sign1;     // rs1 treated as signed
    logic sign2;     // rs2 treated as signed
    logic sel_high;  // multiply returns upper half
    logic sel_rem;   // divide returns remainder
  } mdu_dec_t;

  function automatic mdu_dec_t mdu_decode(input logic [MDU_OP_WIDTH-1:0] op);
    mdu_dec_t d;
    d.is_div   = op[2];
    d.sel_high = ~op[2] & (op[1:0] != 2'b00);
    d.sel_rem  = op[2] & op[1];
    d.sign1    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    d.sign2    = op[2] ? ~op[0] : ~op[1];
    return d;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Unsigned restoring divider: one quotient bit per enabled cycle, MSB first.
// o_done is high during the final iteration; results are valid after that edge.
module mdu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            i_en,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int CNT_W = $clog2(XLEN);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_dvs;

  logic [XLEN:0]    w_shift;
  logic [XLEN:0]    w_diff;
  logic             w_ge;
  logic             w_last;

  // Partial remainder is always below the divisor, so the XLEN+1-bit
  // difference's MSB is a reliable borrow flag.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[XLEN];
  assign w_last  = r_busy && (r_cnt == CNT_W'(XLEN - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
    end else if (i_en) begin
      if (i_abort) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else if (i_start) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
        r_quo  <= i_dividend;
        r_rem  <= '0;
        r_dvs  <= i_divisor;
      end else if (r_busy) begin
        r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], w_ge};
        if (w_last) begin
          r_busy <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_done      = w_last;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/mdu.sv
// RV32M multiply/divide unit: one op at a time, fixed-latency multiply,
// iterative divide with sign fix-up, tagged single-cycle result strobe.
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int TAG_W      = ROB_SIZE_WIDTH + 1,
  parameter int MUL_STAGES = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    need_flush_in,
  input  logic                    valid_in,
  input  logic [MDU_OP_WIDTH-1:0] op_in,
  input  logic [XLEN-1:0]         opr1_in,
  input  logic [XLEN-1:0]         opr2_in,
  input  logic [TAG_W-1:0]        dependency_in,
  output logic                    busy_out,
  output logic [XLEN-1:0]         value_out,
  output logic [TAG_W-1:0]        dependency_out,
  output logic                    ready_out
);

  localparam int MCNT_W   = (MUL_STAGES > 2) ? $clog2(MUL_STAGES) : 1;
  localparam int MUL_INIT = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        r_state;
  logic [MCNT_W-1:0] r_mul_cnt;
  logic [XLEN-1:0]   r_prod;
  logic [TAG_W-1:0]  r_tag;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_sel_rem;
  logic [XLEN-1:0]   r_value;
  logic [TAG_W-1:0]  r_dep;
  logic              r_ready;

  mdu_dec_t          w_dec;
  logic              w_accept;
  logic [2*XLEN-1:0] w_mul_a;
  logic [2*XLEN-1:0] w_mul_b;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;
  logic              w_neg1;
  logic              w_neg2;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_div_special;
  logic [XLEN-1:0]   w_special_val;
  logic              w_div_start;
  logic              w_div_done;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;

  assign w_dec    = mdu_decode(op_in);
  assign w_accept = rdy_in && !need_flush_in && valid_in && (r_state == MDU_S_IDLE);

  // Extending to 2*XLEN and keeping the low 2*XLEN bits gives the same bits
  // as the exact (XLEN+1)x(XLEN+1) signed product over the range we return.
  assign w_mul_a   = {{XLEN{w_dec.sign1 & opr1_in[XLEN-1]}}, opr1_in};
  assign w_mul_b   = {{XLEN{w_dec.sign2 & opr2_in[XLEN-1]}}, opr2_in};
  assign w_prod    = w_mul_a * w_mul_b;
  assign w_mul_res = w_dec.sel_high ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];

  assign w_neg1 = w_dec.sign1 & opr1_in[XLEN-1];
  assign w_neg2 = w_dec.sign2 & opr2_in[XLEN-1];
  assign w_mag1 = w_neg1 ? -opr1_in : opr1_in;
  assign w_mag2 = w_neg2 ? -opr2_in : opr2_in;

  // Divide-by-zero and signed overflow bypass the iterative core entirely.
  assign w_div_zero    = (opr2_in == '0);
  assign w_div_ovf     = w_dec.sign1 && (opr1_in == INT_MIN) && (opr2_in == '1);
  assign w_div_special = w_div_zero || w_div_ovf;
  assign w_special_val = w_div_zero ? (w_dec.sel_rem ? opr1_in : '1)
                                    : (w_dec.sel_rem ? '0 : opr1_in);
  assign w_div_start   = w_accept && w_dec.is_div && !w_div_special;

  mdu_divider #(
    .XLEN (XLEN)
  ) u_divider (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .i_en        (rdy_in),
    .i_start     (w_div_start),
    .i_abort     (need_flush_in),
    .i_dividend  (w_mag1),
    .i_divisor   (w_mag2),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  assign w_quo_fix = r_neg_q ? -w_quo : w_quo;
  assign w_rem_fix = r_neg_r ? -w_rem : w_rem;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= MDU_S_IDLE;
      r_mul_cnt <= '0;
      r_prod    <= '0;
      r_tag     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_sel_rem <= 1'b0;
      r_value   <= '0;
      r_dep     <= '1;
      r_ready   <= 1'b0;
    end else if (rdy_in) begin
      r_ready <= 1'b0;
      if (need_flush_in) begin
        r_state   <= MDU_S_IDLE;
        r_mul_cnt <= '0;
      end else begin
        case (r_state)
          MDU_S_IDLE: begin
            if (valid_in) begin
              r_tag <= dependency_in;
              if (w_dec.is_div) begin
                r_neg_q   <= w_neg1 ^ w_neg2;
                r_neg_r   <= w_neg1;
                r_sel_rem <= w_dec.sel_rem;
                if (w_div_special) begin
                  r_value <= w_special_val;
                  r_dep   <= dependency_in;
                  r_ready <= 1'b1;
                end else begin
                  r_state <= MDU_S_DIV;
                end
              end else if (MUL_STAGES == 1) begin
                r_value <= w_mul_res;
                r_dep   <= dependency_in;
                r_ready <= 1'b1;
              end else begin
                r_state   <= MDU_S_MUL;
                r_prod    <= w_mul_res;
                r_mul_cnt <= MCNT_W'(MUL_INIT);
              end
            end
          end
          MDU_S_MUL: begin
            if (r_mul_cnt == '0) begin
              r_value <= r_prod;
              r_dep   <= r_tag;
              r_ready <= 1'b1;
              r_state <= MDU_S_IDLE;
            end else begin
              r_mul_cnt <= r_mul_cnt - MCNT_W'(1);
            end
          end
          MDU_S_DIV: begin
            if (w_div_done) begin
              r_state <= MDU_S_FIX;
            end
          end
          MDU_S_FIX: begin
            r_value <= r_sel_rem ? w_rem_fix : w_quo_fix;
            r_dep   <= r_tag;
            r_ready <= 1'b1;
            r_state <= MDU_S_IDLE;
          end
          default: r_state <= MDU_S_IDLE;
        endcase
      end
    end
  end

  assign busy_out       = (r_state != MDU_S_IDLE);
  assign value_out      = r_value;
  assign dependency_out = r_dep;
  assign ready_out      = r_ready;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: the driver pushes model results on accept, a
// negedge monitor pops and checks value, tag, latency and busy duration.
module tb_mdu;
  import mdu_pkg::*;

  localparam int XLEN = 32;
  localparam int TAG_W = 5;
  localparam int MUL_STAGES = 2;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdy_in;
  logic              need_flush_in;
  logic              valid_in;
  logic [2:0]        op_in;
  logic [XLEN-1:0]   opr1_in;
  logic [XLEN-1:0]   opr2_in;
  logic [TAG_W-1:0]  dependency_in;
  logic              busy_out;
  logic [XLEN-1:0]   value_out;
  logic [TAG_W-1:0]  dependency_out;
  logic              ready_out;

  mdu #(
    .XLEN       (XLEN),
    .TAG_W      (TAG_W),
    .MUL_STAGES (MUL_STAGES)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .need_flush_in  (need_flush_in),
    .valid_in       (valid_in),
    .op_in          (op_in),
    .opr1_in        (opr1_in),
    .opr2_in        (opr2_in),
    .dependency_in  (dependency_in),
    .busy_out       (busy_out),
    .value_out      (value_out),
    .dependency_out (dependency_out),
    .ready_out      (ready_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [2:0]       op;
    logic [XLEN-1:0]  val;
    logic [TAG_W-1:0] tag;
    int               lat;
    int               acc_en;
    int               acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  logic last_en = 1'b0;
  int   tag_ctr = 0;

  always @(posedge clk_in) begin
    cyc     <= cyc + 1;
    en_cnt  <= en_cnt + (rdy_in ? 1 : 0);
    last_en <= rdy_in;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the RV32M definitions.
  function automatic logic [XLEN-1:0] ref_model(input logic [2:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    longint sa, sb_, ua, ub;
    longint unsigned up;
    logic [63:0] p;
    logic [XLEN-1:0] r;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    r = '0;
    case (op)
      MDU_MUL:    begin p = sa * sb_; r = p[31:0];  end
      MDU_MULH:   begin p = sa * sb_; r = p[63:32]; end
      MDU_MULHSU: begin p = sa * ub;  r = p[63:32]; end
      MDU_MULHU:  begin up = 64'(ua) * 64'(ub); p = up; r = p[63:32]; end
      MDU_DIV: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb_; r = p[31:0]; end
      end
      MDU_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      MDU_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin p = sa % sb_; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    if (op < 3'd4) return MUL_STAGES;
    if (b == 0) return 1;
    if ((op == MDU_DIV || op == MDU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input int stall_pct);
    exp_t e;
    bit   acc;
    bit   done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      rdy_in = ($urandom_range(0, 99) >= stall_pct);
      if (!busy_out) begin
        valid_in      = 1'b1;
        op_in         = op;
        opr1_in       = a;
        opr2_in       = b;
        dependency_in = TAG_W'(tag_ctr);
      end else begin
        valid_in = 1'b0;
      end
      acc = rdy_in && !busy_out && !need_flush_in;
      step();
      if (acc) begin
        e.op      = op;
        e.val     = ref_model(op, a, b);
        e.tag     = TAG_W'(tag_ctr);
        e.lat     = ref_latency(op, a, b);
        e.acc_en  = en_cnt;
        e.acc_cyc = cyc;
        sb.push_back(e);
        tag_ctr++;
        done = 1'b1;
      end
    end
    valid_in = 1'b0;
    rdy_in   = 1'b1;
    if (!done) chk("issue_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [XLEN-1:0] rnd_opr(input bit is_b);
    logic [XLEN-1:0] v;
    case ($urandom_range(0, 7))
      0: v = is_b ? 32'h0 : 32'h8000_0000;
      1: v = is_b ? 32'hFFFF_FFFF : 32'($urandom_range(0, 15));
      2: v = 32'($urandom_range(1, 9));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  // Monitor: one result per edge that raised ready_out while enabled.
  initial begin
    exp_t e;
    int   busy_run;
    busy_run = 0;
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        if (ready_out && last_en) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got value %h tag %h, required no result",
                     value_out, dependency_out);
          end else begin
            e = sb.pop_front();
            $display("result op=%0d value=%h tag=%0d (model %h tag %0d)",
                     e.op, value_out, dependency_out, e.val, e.tag);
            chk("value", 64'(value_out), 64'(e.val));
            chk("tag", 64'(dependency_out), 64'(e.tag));
            chk("latency", 64'(en_cnt - e.acc_en), 64'(e.lat - 1));
            chk("busy_cycles", 64'(busy_run), 64'(cyc - e.acc_cyc));
          end
          busy_run = 0;
        end else if (busy_out) begin
          busy_run++;
        end else begin
          busy_run = 0;
        end
      end
    end
  end

  initial begin
    logic [2:0] rop;
    rst_in        = 1'b1;
    rdy_in        = 1'b1;
    need_flush_in = 1'b0;
    valid_in      = 1'b0;
    op_in         = '0;
    opr1_in       = '0;
    opr2_in       = '0;
    dependency_in = '0;
    #2;
    chk("reset_value", 64'(value_out), 64'h0);
    chk("reset_dep", 64'(dependency_out), 64'h1F);
    chk("reset_ready", 64'(ready_out), 64'h0);
    chk("reset_busy", 64'(busy_out), 64'h0);
    step();
    rst_in = 1'b0;
    step();

    // Directed cases, issued back to back.
    issue(MDU_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 0);
    issue(MDU_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(MDU_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(MDU_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(MDU_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 0);
    issue(MDU_REM,    32'hFFFF_FFF9, 32'h0000_0002, 0);
    issue(MDU_DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 0);
    issue(MDU_DIV,    32'h0000_0005, 32'h0000_0000, 0);
    issue(MDU_REMU,   32'h0000_0005, 32'h0000_0000, 0);
    issue(MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0);
    repeat (40) step();

    // Flush mid-divide with a competing valid op.
    issue(MDU_DIV, 32'h0000_1234, 32'h0000_0007, 0);
    repeat (9) step();
    need_flush_in = 1'b1;
    valid_in      = 1'b1;
    op_in         = MDU_MUL;
    opr1_in       = 32'd3;
    opr2_in       = 32'd4;
    step();
    need_flush_in = 1'b0;
    valid_in      = 1'b0;
    sb.delete();
    chk("flush_busy", 64'(busy_out), 64'h0);
    chk("flush_ready", 64'(ready_out), 64'h0);
    repeat (40) step();
    issue(MDU_REM, 32'h0000_1234, 32'h0000_0007, 0);

    // Flush on the edge that would complete a multiply.
    issue(MDU_MUL, 32'd11, 32'd13, 0);
    need_flush_in = 1'b1;
    step();
    need_flush_in = 1'b0;
    sb.delete();
    chk("flush_done_ready", 64'(ready_out), 64'h0);
    chk("flush_done_busy", 64'(busy_out), 64'h0);
    step();

    // Stall mid-divide, then a multiply issued in the result cycle.
    issue(MDU_DIVU, 32'hDEAD_BEEF, 32'h0000_0123, 0);
    repeat (10) step();
    rdy_in = 1'b0;
    repeat (5) step();
    rdy_in = 1'b1;
    issue(MDU_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    repeat (4) step();

    // Randomised traffic with sporadic stalls.
    for (int i = 0; i < 80; i++) begin
      rop = 3'($urandom_range(0, 7));
      issue(rop, rnd_opr(1'b0), rnd_opr(1'b1), 10);
    end
    for (int n = 0; n < 200 && sb.size() > 0; n++) step();

    // Reset in the middle of a divide.
    issue(MDU_DIV, 32'h7654_3210, 32'h0000_0033, 0);
    repeat (5) step();
    rst_in = 1'b1;
    #1;
    chk("midrst_value", 64'(value_out), 64'h0);
    chk("midrst_dep", 64'(dependency_out), 64'h1F);
    chk("midrst_ready", 64'(ready_out), 64'h0);
    chk("midrst_busy", 64'(busy_out), 64'h0);
    sb.delete();
    #1;
    rst_in = 1'b0;
    step();
    issue(MDU_MUL, 32'h0001_0001, 32'h0001_0001, 0);
    issue(MDU_DIV, 32'h8000_0001, 32'h0000_0003, 0);

    for (int n = 0; n < 200 && sb.size() > 0; n++) step();
    if (sb.size() != 0) chk("drain", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
